// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between a FIFO user and the fifo_ctrl pointer/occupancy controller.
// The master drives the requests; the slave (the controller) returns addresses and flags.
interface fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 2
);
  logic                  wr;
  logic                  rd;
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output wr, rd,
    input  w_en, w_addr, r_addr, empty, full, count
  );

  modport slave (
    input  wr, rd,
    output w_en, w_addr, r_addr, empty, full, count
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/occupancy controller: each accepted write fills two entries,
// and each accepted read drains one entry.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  fifo_ctrl_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH    = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_THR = DEPTH - (ADDR_WIDTH+1)'(2);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [ADDR_WIDTH:0]   w_cnt_nxt;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  // Acceptance is judged on the pre-edge count only; a same-cycle read never frees room for a write.
  always_comb begin
    w_empty   = (r_cnt == (ADDR_WIDTH+1)'(0));
    w_full    = (r_cnt > FULL_THR);
    w_wr_acc  = bus.wr & ~w_full;
    w_rd_acc  = bus.rd & ~w_empty;
    w_cnt_nxt = r_cnt;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_cnt_nxt = r_cnt + (ADDR_WIDTH+1)'(2);
      2'b01:   w_cnt_nxt = r_cnt - (ADDR_WIDTH+1)'(1);
      2'b11:   w_cnt_nxt = r_cnt + (ADDR_WIDTH+1)'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Pointer and occupancy state; pointers wrap by truncation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= ADDR_WIDTH'(0);
      r_rd_ptr <= ADDR_WIDTH'(0);
      r_cnt    <= (ADDR_WIDTH+1)'(0);
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(2);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      r_cnt <= w_cnt_nxt;
    end
  end

  // Output mapping; the write enable is forced low while reset is held.
  always_comb begin
    bus.w_en   = w_wr_acc & reset_n;
    bus.w_addr = r_wr_ptr;
    bus.r_addr = r_rd_ptr;
    bus.empty  = w_empty;
    bus.full   = w_full;
    bus.count  = r_cnt;
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl (ADDR_WIDTH = 2, four entries) with a small byte-wide register-file model.
module tb_fifo_ctrl;

  logic        clk;
  logic        reset_n;
  logic [15:0] w_data;
  logic [7:0]  mem [0:3];
  logic [7:0]  r_data;
  int          n_checks;
  int          n_fail;

  fifo_ctrl_if #(.ADDR_WIDTH(2)) bus ();

  fifo_ctrl #(.ADDR_WIDTH(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: high byte at w_addr, low byte at w_addr+1 (2-bit wrap).
  always @(posedge clk) begin
    if (bus.w_en) begin
      mem[bus.w_addr]          <= w_data[15:8];
      mem[bus.w_addr + 2'd1]   <= w_data[7:0];
    end
  end
  assign r_data = mem[bus.r_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input int wa, input int ra, input int cnt,
                             input int emp, input int ful);
    check({tag, ".w_addr"}, 32'(bus.w_addr), wa[31:0]);
    check({tag, ".r_addr"}, 32'(bus.r_addr), ra[31:0]);
    check({tag, ".count"},  32'(bus.count),  cnt[31:0]);
    check({tag, ".empty"},  32'(bus.empty),  emp[31:0]);
    check({tag, ".full"},   32'(bus.full),   ful[31:0]);
  endtask

  // Apply wr/rd at the falling edge, check w_en before the rising edge, return 1 ns after it.
  task automatic step(input logic wr, input logic rd, input logic exp_wen, input string tag);
    @(negedge clk);
    bus.wr = wr;
    bus.rd = rd;
    #1;
    check({tag, ".w_en"}, 32'(bus.w_en), 32'(exp_wen));
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    w_data   = 16'h0000;
    bus.wr   = 1'b1;
    bus.rd   = 1'b0;
    reset_n  = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;

    // Reset held with wr asserted
    repeat (3) @(posedge clk);
    #1;
    check("rst.w_en", 32'(bus.w_en), 32'd0);
    check_state("rst", 0, 0, 0, 1, 0);
    @(negedge clk);
    bus.wr  = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_state("idle", 0, 0, 0, 1, 0);

    // Fill
    w_data = 16'h1122;
    step(1'b1, 1'b0, 1'b1, "fill1");
    check_state("fill1", 2, 0, 2, 0, 0);
    step(1'b1, 1'b0, 1'b1, "fill2");
    check_state("fill2", 0, 0, 4, 0, 1);
    step(1'b1, 1'b0, 1'b0, "fill3");
    check_state("fill3", 0, 0, 4, 0, 1);

    // Drain with full hysteresis
    step(1'b0, 1'b1, 1'b0, "drain1");
    check_state("drain1", 0, 1, 3, 0, 1);
    step(1'b0, 1'b1, 1'b0, "drain2");
    check_state("drain2", 0, 2, 2, 0, 0);
    step(1'b0, 1'b1, 1'b0, "drain3");
    step(1'b0, 1'b1, 1'b0, "drain4");
    check_state("drain4", 0, 0, 0, 1, 0);
    step(1'b0, 1'b1, 1'b0, "drain5");
    check_state("drain5", 0, 0, 0, 1, 0);

    // Simultaneous requests
    step(1'b1, 1'b1, 1'b1, "sim0");
    check_state("sim0", 2, 0, 2, 0, 0);
    step(1'b1, 1'b1, 1'b1, "sim2");
    check_state("sim2", 0, 1, 3, 0, 1);
    step(1'b1, 1'b1, 1'b0, "sim3");
    check_state("sim3", 0, 2, 2, 0, 0);
    step(1'b0, 1'b1, 1'b0, "simd1");
    step(1'b0, 1'b1, 1'b0, "simd2");
    check_state("simd", 0, 0, 0, 1, 0);

    // Data ordering: high byte read before low byte
    w_data = 16'h3C4D;
    step(1'b1, 1'b0, 1'b1, "ord_w1");
    w_data = 16'hA1B2;
    step(1'b1, 1'b0, 1'b1, "ord_w2");
    check_state("ord_full", 0, 0, 4, 0, 1);
    check("ord.rd0", 32'(r_data), 32'h3C);
    step(1'b0, 1'b1, 1'b0, "ord_r0");
    check("ord.rd1", 32'(r_data), 32'h4D);
    step(1'b0, 1'b1, 1'b0, "ord_r1");
    check("ord.rd2", 32'(r_data), 32'hA1);
    step(1'b0, 1'b1, 1'b0, "ord_r2");
    check("ord.rd3", 32'(r_data), 32'hB2);
    step(1'b0, 1'b1, 1'b0, "ord_r3");
    check_state("ord_end", 0, 0, 0, 1, 0);

    // Asynchronous reset mid-stream at count 3
    step(1'b1, 1'b0, 1'b1, "ar_w1");
    step(1'b1, 1'b0, 1'b1, "ar_w2");
    step(1'b0, 1'b1, 1'b0, "ar_r1");
    check_state("ar_pre", 0, 1, 3, 0, 1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_state("ar_async", 0, 0, 0, 1, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_state("ar_after", 0, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
